// File: rtl/serial_addsub_unit_pkg.sv
`default_nettype none
// ============================================================================
// serial_addsub_unit_pkg : shared FSM encoding and default sizing
// Rev 1.0
// ============================================================================
package serial_addsub_unit_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_unit_full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : one-bit full adder, chained to form the digit-slice adder
// Rev 1.0
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// serial_addsub_unit : digit-serial add/subtract, DIGIT bits per clock
// Rev 1.0
// ============================================================================
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             enable_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             COUT,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int c_steps = WIDTH / DIGIT;
  localparam int c_cw    = (c_steps > 1) ? $clog2(c_steps) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_steps - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("serial_addsub_unit: WIDTH must be a multiple of DIGIT");
  end

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a_sh;
  logic [WIDTH-1:0]  r_b_sh;
  logic              r_a_msb;
  logic              r_b_msb;
  logic [DIGIT-1:0]  w_slice_sum;
  logic [DIGIT:0]    w_carry;
  logic [WIDTH-1:0]  w_acc_next;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN);

  // Operands are shifted right each step, so the live slice is always bits [DIGIT-1:0]
  assign w_carry[0] = r_carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (r_a_sh[i]),
      .b    (r_b_sh[i]),
      .cin  (w_carry[i]),
      .sum  (w_slice_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  // Partial sums enter at the top and move down, ending LSB-aligned after the last step
  if (c_steps > 1) begin : g_acc
    logic [WIDTH-DIGIT-1:0] r_acc;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_acc_next[WIDTH-1:DIGIT];
      end
    end
    assign w_acc_next = {w_slice_sum, r_acc};
  end else begin : g_no_acc
    assign w_acc_next = w_slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      result   <= '0;
      COUT     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= enable_sub ? ~b : b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1] ^ enable_sub;
            r_carry <= enable_sub;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> DIGIT;
          r_b_sh  <= r_b_sh >> DIGIT;
          r_carry <= w_carry[DIGIT];
          if (r_cnt == c_last) begin
            r_cnt    <= '0;
            result   <= w_acc_next;
            COUT     <= w_carry[DIGIT];
            overflow <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
            zero     <= (w_acc_next == '0);
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
